elevator_controller: RTL and testbench

Elevator motion and door controller for an N-floor car. Consumes the registered request vectors (hall up/down calls, cab calls, door buttons) from the request-register block and drives the car position, motion, and door. Returns the one-cycle clear pulses that retire serviced requests in that block, so the two blocks close the request loop. Sits between the request register and the display/motor outputs.

---
 rtl/elevator_pkg.sv | 35 +++
 rtl/elevator_timer.sv | 32 +++
 rtl/elevator_controller.sv | 214 +++++++++++++++++++++
 tb/tb_elevator_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | elevator_pkg : state encoding, direction constants, floor-mask helper      |
// | rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
package elevator_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MOVE   = 3'd1,
    ARRIVE = 3'd2,
    DOOR   = 3'd3,
    BLANK  = 3'd4
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MAX_FLOORS = 32;

  typedef struct packed {
    logic [MAX_FLOORS-1:0] above;
    logic [MAX_FLOORS-1:0] below;
  } floor_masks_t;

  // For a one-hot position, cur-1 sets every bit strictly below it.
  function automatic floor_masks_t floor_masks(input logic [MAX_FLOORS-1:0] cur);
    floor_masks_t m;
    m.below = cur - MAX_FLOORS'(1);
    m.above = ~(cur | m.below);
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_timer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | elevator_timer : loadable down-counter, done while the count is zero       |
// | rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module elevator_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/elevator_controller.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | elevator_controller : car motion/door FSM closing the request-clear loop   |
// | rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int N           = 6,
  parameter int MOVE_CYCLES = 50,
  parameter int DOOR_CYCLES = 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] up,
  input  logic [N-1:0] down,
  input  logic [N-1:0] req_in,
  input  logic         close_button,
  input  logic         open_button,
  output logic [N-1:0] cur_floor,
  output logic         dir_up,
  output logic         moving_up,
  output logic         moving_down,
  output logic         door_open,
  output logic         clear_stop,
  output logic         clear_up,
  output logic         clear_down,
  output logic         clear_door,
  output logic         clear_all_up,
  output logic         clear_all_down
);

  localparam int MAX_CYCLES = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
  localparam logic [TIMER_W-1:0] MOVE_LOAD = TIMER_W'(MOVE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD = TIMER_W'(DOOR_CYCLES - 1);

  state_t               state, state_next;
  logic [N-1:0]         cur_next;
  logic                 dir_next;
  logic                 stop_next, up_next, down_next, door_next;
  logic                 timer_load, timer_enable, timer_done;
  logic [TIMER_W-1:0]   timer_value;

  logic [MAX_FLOORS-1:0] cur_ext, req_ext;
  floor_masks_t          masks;
  logic                  above, below, ahead, stop_here, busy;
  logic [N-1:0]          dir_calls, opp_calls;

  always_comb begin
    cur_ext = '0;
    cur_ext[N-1:0] = cur_floor;
    req_ext = '0;
    req_ext[N-1:0] = up | down | req_in;
  end

  assign masks = floor_masks(cur_ext);
  assign above = |(req_ext & masks.above);
  assign below = |(req_ext & masks.below);
  assign ahead = dir_up ? above : below;

  // Opposite-direction calls at this floor wait until nothing lies ahead, so
  // a car stopping on the way keeps them pending for the return sweep.
  assign dir_calls = dir_up ? up : down;
  assign opp_calls = dir_up ? down : up;
  assign stop_here = (|((req_in | dir_calls) & cur_floor)) ||
                     ((|(opp_calls & cur_floor)) && !ahead);

  // Request vectors are stale while a clear is in flight.
  assign busy = clear_stop | clear_up | clear_down | clear_door;

  assign clear_all_up   = 1'b0;
  assign clear_all_down = 1'b0;

  elevator_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .enable    (timer_enable),
    .done      (timer_done)
  );

  always_comb begin
    state_next   = state;
    cur_next     = cur_floor;
    dir_next     = dir_up;
    stop_next    = 1'b0;
    up_next      = 1'b0;
    down_next    = 1'b0;
    door_next    = 1'b0;
    timer_load   = 1'b0;
    timer_value  = DOOR_LOAD;
    timer_enable = (state == MOVE) || (state == DOOR);
    moving_up    = 1'b0;
    moving_down  = 1'b0;
    door_open    = 1'b0;

    case (state)
      IDLE: begin
        if (!busy) begin
          if (open_button) begin
            door_next  = 1'b1;
            timer_load = 1'b1;
            state_next = DOOR;
          end else if (stop_here) begin
            up_next    = ahead && dir_up;
            down_next  = ahead && !dir_up;
            stop_next  = !ahead;
            timer_load = 1'b1;
            state_next = DOOR;
          end else if (above || below) begin
            dir_next    = above ? DIR_UP : DIR_DOWN;
            timer_load  = 1'b1;
            timer_value = MOVE_LOAD;
            state_next  = MOVE;
          end
        end
      end

      MOVE: begin
        moving_up   = dir_up;
        moving_down = !dir_up;
        if (timer_done) begin
          if (dir_up && !cur_floor[N-1]) begin
            cur_next = cur_floor << 1;
          end else if (!dir_up && !cur_floor[0]) begin
            cur_next = cur_floor >> 1;
          end
          state_next = ARRIVE;
        end
      end

      ARRIVE: begin
        if (!busy) begin
          if (stop_here) begin
            up_next    = ahead && dir_up;
            down_next  = ahead && !dir_up;
            stop_next  = !ahead;
            if (!ahead && (dir_up ? below : above)) begin
              dir_next = !dir_up;
            end
            timer_load = 1'b1;
            state_next = DOOR;
          end else if (ahead) begin
            timer_load  = 1'b1;
            timer_value = MOVE_LOAD;
            state_next  = MOVE;
          end else begin
            state_next = IDLE;
          end
        end
      end

      DOOR: begin
        door_open = 1'b1;
        if (!busy && open_button) begin
          door_next  = 1'b1;
          timer_load = 1'b1;
        end else if (!busy && close_button) begin
          // Expire on the next cycle so the door stays open through the pulse.
          door_next   = 1'b1;
          timer_load  = 1'b1;
          timer_value = '0;
        end else if (!busy && stop_here) begin
          up_next    = ahead && dir_up;
          down_next  = ahead && !dir_up;
          stop_next  = !ahead;
          timer_load = 1'b1;
        end else if (timer_done) begin
          state_next = BLANK;
        end
      end

      BLANK: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cur_floor  <= N'(1);
      dir_up     <= DIR_UP;
      clear_stop <= 1'b0;
      clear_up   <= 1'b0;
      clear_down <= 1'b0;
      clear_door <= 1'b0;
    end else begin
      state      <= state_next;
      cur_floor  <= cur_next;
      dir_up     <= dir_next;
      clear_stop <= stop_next;
      clear_up   <= up_next;
      clear_down <= down_next;
      clear_door <= door_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && (state == MOVE) && timer_done) begin
      assert (dir_up ? !cur_floor[N-1] : !cur_floor[0]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_elevator_controller.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_elevator_controller : directed trips plus hand-timed door/reset cases  |
// | rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module tb_elevator_controller;

  localparam int N  = 6;
  localparam int MC = 4;
  localparam int DC = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] up_r = '0, down_r = '0, req_r = '0;
  logic         open_r = 1'b0, close_r = 1'b0;
  logic [N-1:0] cur_floor;
  logic dir_up, moving_up, moving_down, door_open;
  logic clear_stop, clear_up, clear_down, clear_door, clear_all_up, clear_all_down;

  always #5 clk = ~clk;

  elevator_controller #(.N(N), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .up(up_r), .down(down_r), .req_in(req_r),
    .close_button(close_r), .open_button(open_r), .cur_floor(cur_floor),
    .dir_up(dir_up), .moving_up(moving_up), .moving_down(moving_down),
    .door_open(door_open), .clear_stop(clear_stop), .clear_up(clear_up),
    .clear_down(clear_down), .clear_door(clear_door),
    .clear_all_up(clear_all_up), .clear_all_down(clear_all_down)
  );

  int tests = 0, fails = 0;
  int cyc, n_stop, n_up, n_down, n_door, door_cycles;
  int n_multi = 0, n_motor = 0, n_all = 0;
  logic p_stop = 0, p_up = 0, p_down = 0, p_door = 0;
  logic [N-1:0] p_cur = '0;

  typedef struct {
    logic [N-1:0] up, down, req;
    logic         open;
    logic [N-1:0] floor;
    logic         dir;
    int           stops, ups, downs, doors;
  } trip_t;
  trip_t trips[8];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pulses();
    return int'(clear_stop) + int'(clear_up) + int'(clear_down) + int'(clear_door);
  endfunction

  // One cycle at the negedge; the request-register neighbour retires what the
  // previous cycle's pulses asked for, one cycle after the pulse.
  task automatic step();
    @(negedge clk);
    if (p_stop) begin up_r &= ~p_cur; down_r &= ~p_cur; req_r &= ~p_cur; end
    if (p_up)   begin up_r &= ~p_cur; req_r &= ~p_cur; end
    if (p_down) begin down_r &= ~p_cur; req_r &= ~p_cur; end
    if (p_door) begin open_r = 1'b0; close_r = 1'b0; end
    p_stop = clear_stop; p_up = clear_up; p_down = clear_down; p_door = clear_door;
    p_cur  = cur_floor;
    cyc++;
    n_stop += int'(clear_stop); n_up += int'(clear_up);
    n_down += int'(clear_down); n_door += int'(clear_door);
    if (door_open) door_cycles++;
    if (pulses() > 1) n_multi++;
    if (moving_up && moving_down) n_motor++;
    if (clear_all_up || clear_all_down) n_all++;
  endtask

  task automatic reset_counts();
    cyc = 0; n_stop = 0; n_up = 0; n_down = 0; n_door = 0; door_cycles = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    up_r = '0; down_r = '0; req_r = '0; open_r = 1'b0; close_r = 1'b0;
    p_stop = 0; p_up = 0; p_down = 0; p_door = 0;
    reset = 1'b1;
    reset_counts();
  endtask

  task automatic wait_idle(input string name, input int bound);
    int quiet = 0;
    int k = 0;
    while (quiet < 3 && k < bound) begin
      step();
      k++;
      if (up_r == '0 && down_r == '0 && req_r == '0 && !open_r && !close_r &&
          !door_open && !moving_up && !moving_down && pulses() == 0) quiet++;
      else quiet = 0;
    end
    check({name, "_settled"}, int'(quiet >= 3), 1);
  endtask

  initial begin
    int k, first_move, first_step, at_f3, stop_at, door_first, arrive_motor;
    int door_at, down2_kept, dir_at_f4, ups_at_f4, stops_at_f4;

    trips[0] = '{6'b000000, 6'b000000, 6'b001000, 1'b0, 6'b001000, 1'b1, 1, 0, 0, 0};
    trips[1] = '{6'b000000, 6'b000010, 6'b000000, 1'b0, 6'b000010, 1'b0, 1, 0, 0, 0};
    trips[2] = '{6'b010000, 6'b000000, 6'b000100, 1'b0, 6'b010000, 1'b1, 1, 1, 0, 0};
    trips[3] = '{6'b000001, 6'b000000, 6'b000000, 1'b0, 6'b000001, 1'b0, 1, 0, 0, 0};
    trips[4] = '{6'b000000, 6'b100000, 6'b100000, 1'b0, 6'b100000, 1'b1, 1, 0, 0, 0};
    trips[5] = '{6'b000000, 6'b000000, 6'b000000, 1'b1, 6'b100000, 1'b1, 0, 0, 0, 1};
    trips[6] = '{6'b000000, 6'b100000, 6'b000000, 1'b0, 6'b100000, 1'b1, 1, 0, 0, 0};
    trips[7] = '{6'b001000, 6'b000000, 6'b000001, 1'b0, 6'b001000, 1'b1, 2, 0, 0, 0};

    // Reset state and a quiet idle period.
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_floor", int'(cur_floor), 1);
    check("rst_dir", int'(dir_up), 1);
    check("rst_motor", int'(moving_up) + int'(moving_down), 0);
    check("rst_door", int'(door_open), 0);
    check("rst_pulses", pulses() + int'(clear_all_up) + int'(clear_all_down), 0);
    reset = 1'b1;
    reset_counts();
    repeat (20) step();
    check("idle_pulses", n_stop + n_up + n_down + n_door, 0);
    check("idle_activity", door_cycles + int'(moving_up) + int'(moving_down), 0);
    check("idle_floor", int'(cur_floor), 1);

    // Chained trips; each starts where the previous one ended.
    for (int i = 0; i < 8; i++) begin
      reset_counts();
      up_r |= trips[i].up; down_r |= trips[i].down; req_r |= trips[i].req;
      open_r = open_r | trips[i].open;
      wait_idle($sformatf("trip%0d", i), 600);
      check($sformatf("trip%0d_floor", i), int'(cur_floor), int'(trips[i].floor));
      check($sformatf("trip%0d_dir", i), int'(dir_up), int'(trips[i].dir));
      check($sformatf("trip%0d_stops", i), n_stop, trips[i].stops);
      check($sformatf("trip%0d_ups", i), n_up, trips[i].ups);
      check($sformatf("trip%0d_downs", i), n_down, trips[i].downs);
      check($sformatf("trip%0d_doors", i), n_door, trips[i].doors);
    end

    // Cycle-accurate trip 0 -> 3.
    do_reset();
    req_r[3] = 1'b1;
    first_move = -1; first_step = -1; at_f3 = -1; stop_at = -1; door_first = -1;
    arrive_motor = -1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (first_move < 0 && moving_up) first_move = cyc;
      if (first_step < 0 && cur_floor != 6'b000001) first_step = cyc;
      if (at_f3 < 0 && cur_floor == 6'b001000) at_f3 = cyc;
      if (stop_at < 0 && clear_stop) stop_at = cyc;
      if (door_first < 0 && door_open) door_first = cyc;
      if (cyc == 5) arrive_motor = int'(moving_up);
    end
    check("t_first_move", first_move, 1);
    check("t_first_step", first_step, MC + 1);
    check("t_arrive_motor_off", arrive_motor, 0);
    check("t_at_floor3", at_f3, 15);
    check("t_clear_stop_cycle", stop_at, 16);
    check("t_door_first", door_first, 16);
    check("t_door_cycles", door_cycles, DC);
    check("t_stop_count", n_stop, 1);
    check("t_final_floor", int'(cur_floor), 8);

    // Up-call stop keeps the opposite call for the return sweep.
    do_reset();
    up_r[2] = 1'b1; down_r[2] = 1'b1; req_r[4] = 1'b1;
    k = 0;
    while (cur_floor != 6'b010000 && k < 200) begin step(); k++; end
    down2_kept = int'(down_r[2]); ups_at_f4 = n_up; stops_at_f4 = n_stop;
    k = 0; dir_at_f4 = -1;
    while (dir_at_f4 < 0 && k < 50) begin
      step(); k++;
      if (clear_stop) dir_at_f4 = int'(dir_up);
    end
    wait_idle("sweep", 400);
    check("sweep_down2_kept", down2_kept, 1);
    check("sweep_f2_clear_up_only", ups_at_f4 * 10 + stops_at_f4, 10);
    check("sweep_dir_at_f4", dir_at_f4, 0);
    check("sweep_stops", n_stop, 2);
    check("sweep_downs", n_down, 0);
    check("sweep_final_floor", int'(cur_floor), 4);
    check("sweep_final_dir", int'(dir_up), 0);

    // Open button on door cycle 5 restarts the timer.
    do_reset();
    req_r[0] = 1'b1;
    k = 0;
    while (door_cycles < 5 && k < 50) begin step(); k++; end
    open_r = 1'b1;
    wait_idle("reopen", 200);
    check("reopen_door_cycles", door_cycles, DC + 5);
    check("reopen_clear_door", n_door, 1);
    check("reopen_clear_stop", n_stop, 1);

    // Open button and a new cab call at this floor in the same door cycle.
    do_reset();
    req_r[0] = 1'b1;
    k = 0;
    while (door_cycles < 3 && k < 50) begin step(); k++; end
    open_r = 1'b1; req_r[0] = 1'b1;
    door_at = -1; stop_at = -1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (clear_door && door_at < 0) door_at = door_cycles;
      if (clear_stop && stop_at < 0) stop_at = door_cycles;
    end
    wait_idle("both", 200);
    check("both_door_pulse_at", door_at, 4);
    check("both_stop_pulse_at", stop_at, 6);
    check("both_door_cycles", door_cycles, 13);
    check("both_stop_count", n_stop, 2);

    // Close button: door stays open through the clear pulse, then drops.
    do_reset();
    req_r[0] = 1'b1;
    k = 0;
    while (door_cycles < 2 && k < 50) begin step(); k++; end
    close_r = 1'b1;
    door_at = -1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (clear_door && door_at < 0) door_at = door_cycles;
    end
    wait_idle("close", 100);
    check("close_pulse_at", door_at, 3);
    check("close_door_cycles", door_cycles, 3);

    // Asynchronous reset between floors 1 and 2, then restart from floor 0.
    do_reset();
    req_r[4] = 1'b1;
    k = 0;
    while (!(cur_floor == 6'b000010 && moving_up) && k < 100) begin step(); k++; end
    step();
    #2 reset = 1'b0;
    #1;
    check("amid_floor", int'(cur_floor), 1);
    check("amid_dir", int'(dir_up), 1);
    check("amid_motor", int'(moving_up) + int'(moving_down), 0);
    check("amid_door_pulses", int'(door_open) + pulses(), 0);
    repeat (2) @(negedge clk);
    p_stop = 0; p_up = 0; p_down = 0; p_door = 0;
    reset = 1'b1;
    reset_counts();
    step();
    check("amid_restart_move", int'(moving_up), 1);
    check("amid_restart_floor", int'(cur_floor), 1);
    wait_idle("amid", 300);
    check("amid_final_floor", int'(cur_floor), 16);
    check("amid_stops", n_stop, 1);

    check("single_pulse_violations", n_multi, 0);
    check("motor_both_on", n_motor, 0);
    check("clear_all_seen", n_all, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
